i2s_tx: RTL and testbench
=========================

# i2s_tx

Stereo I2S serializer on the audio output path. Takes the mixer's parallel signed samples and drives the codec's serial data line in standard I2S framing: 64 bclk per frame, 32-bit slots, MSB first, one-bclk data delay. Both channels are captured together at the start of each frame, so a stereo pair is always coherent. The block also reports framing errors on the incoming lrclk.

## Interface
- `BITSIZE`, 16: sample width in bits, 2..32. Slot bits beyond `BITSIZE` are zero-padded.
- `bclk` input 1: bit clock; the only clock in the block. All logic updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `lrclk` input 1: word select, synchronous to `bclk`. 0 = left, 1 = right. Generated elsewhere.
- `left` input `BITSIZE`: signed left sample. Sampled only at the frame capture edge.
- `right` input `BITSIZE`: signed right sample. Sampled only at the frame capture edge.
- `sdata` output 1: serial data to the codec. Registered; the codec samples it on falling `bclk`.
- `sample_req` output 1: one-cycle pulse when a stereo pair has been captured.
- `frame_err` output 1: sticky flag for lrclk half-period ≠ 32 bclk. Cleared only by `reset`.

## Operation
- `lr_d` is a registered copy of `lrclk`. A transition edge is any rising `bclk` edge where `lrclk != lr_d`.
- Falling transition (1→0, left slot start):
  - `L_h <= left`, `R_h <= right`.
  - `sample_req <= 1` for exactly one cycle.
  - `sdata <= left[BITSIZE-1]`.
  - `shreg <= left << 1`, built from the current `left` input, not `L_h`.
- Rising transition (0→1, right slot start):
  - `sdata <= R_h[BITSIZE-1]`.
  - `shreg <= R_h << 1`.
- Non-transition edge:
  - `sdata <= shreg[BITSIZE-1]`.
  - `shreg <= shreg << 1`, zero-filled. Bits 0..`BITSIZE-1` of a slot carry data MSB-first; the remaining slot bits are 0.
- Slot counter `cnt` (6 bits):
  - Transition edge: `cnt <= 0`.
  - Otherwise: `cnt <= cnt + 1`, saturating at 63.
- Framing check:
  - `armed` is cleared by reset and set on the first transition edge after reset.
  - On a transition edge with `armed == 1` and `cnt != 31`: `frame_err <= 1`.
- Sample width:
  - Samples are transmitted bit-exact. No rounding or truncation.
  - Two's-complement sign is carried by the MSB only; padding is zeros, not sign extension.
- Inputs `left`/`right` may change at any time. Only values present at the falling-transition edge are used.

## Timing
- Reset values:
  - Outputs: `sdata` = 0, `sample_req` = 0, `frame_err` = 0.
  - Internal: `lr_d` = 0, `shreg` = 0, `L_h` = 0, `R_h` = 0, `cnt` = 0, `armed` = 0.
- Latency:
  - `lrclk` changes after edge T-1 and is seen at edge T; MSB is on `sdata` after edge T. This is the I2S one-bclk delay.
  - Bit k of the slot appears after edge T+k.
- `sample_req` is high for the cycle after edge T of a falling transition. The upstream must present the next pair before the next falling transition, 64 bclk later.
- Right slot uses the `R_h` captured at the preceding left start, not the live `right` input.
- First transition after reset:
  - If `lrclk` = 1 at the first edge, it is a rising transition and the right slot transmits `R_h` = 0.
  - No `frame_err` is raised on this transition.
- Reset mid-word:
  - `sdata` = 0 after the reset edge.
  - Output resumes cleanly at the next transition after `reset` deasserts.
  - `frame_err` is not re-raised on the first post-reset transition.
- Short or long half-frames set `frame_err`. Data is still serialized, truncated or zero-extended by the actual slot length.
- `reset` asserted on a transition edge wins: no capture, no pulse.

## Test plan
- Nominal, `BITSIZE`=16:
  - Stimulus: `left`=16'hA5F0, `right`=16'h0F0F, lrclk 32/32.
  - Required: left slot bits = 1010010111110000 followed by 16 zeros; right slot bits = 0000111100001111 followed by 16 zeros.
  - Required: `sample_req` pulses once per 64 bclk; `frame_err` stays 0.
- Coherency:
  - Stimulus: change `right` from 16'h1234 to 16'h7FFF during the left slot.
  - Required: the right slot still sends 16'h1234; 16'h7FFF appears in the next frame.
- `BITSIZE`=24:
  - Stimulus: `left`=24'h800001.
  - Required: MSB 1, then 22 zeros, then 1, then 8 zeros; slot total = 32 bits.
- Framing error:
  - Stimulus: one lrclk half-period of 30 bclk after two good frames.
  - Required: `frame_err` rises at that transition edge and stays 1 until `reset`.
- Reset mid-word:
  - Stimulus: assert `reset` for 1 cycle at bit 5 of the left slot.
  - Required: `sdata` = 0 until the next transition; the next slot is correct; `frame_err` = 0.
- Start-up:
  - Stimulus: `lrclk` = 1 at reset release.
  - Required: the first right slot is all zeros; the first `sample_req` occurs at the first falling transition.

Source files
------------

// File: rtl/i2s_tx_if.sv
// i2s_tx_if: signal bundle between an I2S frame source/sink and i2s_tx.
//   lrclk      word select, 0 = left slot, 1 = right slot
//   left       signed left sample, BITSIZE bits
//   right      signed right sample, BITSIZE bits
//   sdata      serial data towards the codec
//   sample_req one-cycle pulse when a stereo pair has been captured
//   frame_err  sticky lrclk framing error flag
// master: the side that supplies lrclk and samples; slave: the serializer.
interface i2s_tx_if #(
  parameter int BITSIZE = 16
);
  logic                      lrclk;
  logic signed [BITSIZE-1:0] left;
  logic signed [BITSIZE-1:0] right;
  logic                      sdata;
  logic                      sample_req;
  logic                      frame_err;

  modport master (
    output lrclk, left, right,
    input  sdata, sample_req, frame_err
  );

  modport slave (
    input  lrclk, left, right,
    output sdata, sample_req, frame_err
  );
endinterface

// File: rtl/i2s_tx.sv
// i2s_tx: stereo I2S serializer. 64 bclk per frame, 32-bit slots, MSB
// first, one-bclk data delay after each lrclk transition. Both samples are
// captured together at the left-slot start so a stereo pair is coherent.
// Slot bits beyond BITSIZE are zero. lrclk half-periods other than 32 bclk
// set a sticky frame_err.
// Ports:
//   bclk   bit clock, all logic on its rising edge
//   reset  synchronous, active-high
//   bus    i2s_tx_if slave: lrclk/left/right in, sdata/sample_req/frame_err out
module i2s_tx #(
  parameter int BITSIZE = 16
) (
  input  logic     bclk,
  input  logic     reset,
  i2s_tx_if.slave  bus
);

  localparam logic [5:0] CNT_MAX  = 6'd63;
  localparam logic [5:0] CNT_GOOD = 6'd31;

  logic                      lr_d;
  logic [BITSIZE-1:0]        shreg;
  logic signed [BITSIZE-1:0] l_h;
  logic signed [BITSIZE-1:0] r_h;
  logic [5:0]                cnt;
  logic                      armed;
  logic                      sdata_q;
  logic                      sreq_q;
  logic                      ferr_q;

  logic [BITSIZE-1:0]        shreg_nxt;
  logic signed [BITSIZE-1:0] l_h_nxt;
  logic signed [BITSIZE-1:0] r_h_nxt;
  logic [5:0]                cnt_nxt;
  logic                      armed_nxt;
  logic                      sdata_nxt;
  logic                      sreq_nxt;
  logic                      ferr_nxt;

  logic                      is_edge;
  logic                      is_fall;
  logic                      is_rise;

  // Slot bit counter saturates so an lrclk that stops toggling cannot
  // wrap back to a value that looks like a good half-period.
  function automatic logic [5:0] sat_inc(input logic [5:0] c);
    return (c == CNT_MAX) ? c : c + 6'd1;
  endfunction

  assign is_edge = (bus.lrclk != lr_d);
  assign is_fall = is_edge & ~bus.lrclk;
  assign is_rise = is_edge &  bus.lrclk;

  always_comb begin
    l_h_nxt   = l_h;
    r_h_nxt   = r_h;
    sreq_nxt  = 1'b0;
    sdata_nxt = shreg[BITSIZE-1];
    shreg_nxt = {shreg[BITSIZE-2:0], 1'b0};
    cnt_nxt   = sat_inc(cnt);
    armed_nxt = armed;
    ferr_nxt  = ferr_q;

    if (is_fall) begin
      // Left slot start: the live left input goes straight to the wire so
      // the MSB leaves one bclk after the transition, not two.
      l_h_nxt   = bus.left;
      r_h_nxt   = bus.right;
      sreq_nxt  = 1'b1;
      sdata_nxt = bus.left[BITSIZE-1];
      shreg_nxt = {bus.left[BITSIZE-2:0], 1'b0};
    end else if (is_rise) begin
      // Right slot uses the pair captured at the preceding left start.
      sdata_nxt = r_h[BITSIZE-1];
      shreg_nxt = {r_h[BITSIZE-2:0], 1'b0};
    end

    if (is_edge) begin
      cnt_nxt   = 6'd0;
      armed_nxt = 1'b1;
      // The first transition after reset only arms the check; the count
      // before it does not describe a full half-period.
      if (armed && (cnt != CNT_GOOD)) begin
        ferr_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge bclk) begin
    if (reset) begin
      lr_d    <= 1'b0;
      shreg   <= '0;
      l_h     <= '0;
      r_h     <= '0;
      cnt     <= '0;
      armed   <= 1'b0;
      sdata_q <= 1'b0;
      sreq_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      lr_d    <= bus.lrclk;
      shreg   <= shreg_nxt;
      l_h     <= l_h_nxt;
      r_h     <= r_h_nxt;
      cnt     <= cnt_nxt;
      armed   <= armed_nxt;
      sdata_q <= sdata_nxt;
      sreq_q  <= sreq_nxt;
      ferr_q  <= ferr_nxt;
    end
  end

  assign bus.sdata      = sdata_q;
  assign bus.sample_req = sreq_q;
  assign bus.frame_err  = ferr_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench for i2s_tx with a 16-bit and a 24-bit instance
// sharing one lrclk. Each slot is collected as a 32-bit word (slot bit 0 in
// bit 31) and compared against hand-computed slot words.
module tb_i2s_tx;

  logic        bclk;
  logic        reset;
  logic        lr;
  logic [15:0] l16, r16;
  logic [23:0] l24, r24;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] b16, b24, sq;
  logic        fe0;

  i2s_tx_if #(.BITSIZE(16)) bus16 ();
  i2s_tx_if #(.BITSIZE(24)) bus24 ();

  assign bus16.lrclk = lr;
  assign bus16.left  = l16;
  assign bus16.right = r16;
  assign bus24.lrclk = lr;
  assign bus24.left  = l24;
  assign bus24.right = r24;

  i2s_tx #(.BITSIZE(16)) dut16 (.bclk(bclk), .reset(reset), .bus(bus16));
  i2s_tx #(.BITSIZE(24)) dut24 (.bclk(bclk), .reset(reset), .bus(bus24));

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  // One lrclk half-period of len bclk. lrclk changes right after the
  // previous edge, so the first edge inside the loop is the transition edge.
  // chg_k: edge index at which r16 switches to r16_new (-1 = never).
  // rst_k: edge index at which reset is asserted for one cycle (-1 = never).
  task automatic run_half(input int len, input logic lv, input int chg_k,
                          input logic [15:0] r16_new, input int rst_k);
    lr  = lv;
    b16 = '0;
    b24 = '0;
    sq  = '0;
    fe0 = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (k == rst_k) reset = 1'b1;
      if (k == chg_k) r16 = r16_new;
      tick();
      reset = 1'b0;
      b16[31-k] = bus16.sdata;
      b24[31-k] = bus24.sdata;
      sq[31-k]  = bus16.sample_req;
      if (k == 0) fe0 = bus16.frame_err;
    end
  endtask

  task automatic frame_chk(input string tag,
                           input logic [31:0] xl16, input logic [31:0] xr16,
                           input logic [31:0] xl24, input logic [31:0] xr24,
                           input logic xfe);
    run_half(32, 1'b0, -1, 16'h0, -1);
    check({tag, " L16"}, b16, xl16);
    check({tag, " L24"}, b24, xl24);
    check({tag, " sreqL"}, sq, 32'h8000_0000);
    run_half(32, 1'b1, -1, 16'h0, -1);
    check({tag, " R16"}, b16, xr16);
    check({tag, " R24"}, b24, xr24);
    check({tag, " sreqR"}, sq, 32'h0);
    check({tag, " ferr16"}, bus16.frame_err, xfe);
    check({tag, " ferr24"}, bus24.frame_err, xfe);
  endtask

  initial begin
    reset = 1'b1;
    lr    = 1'b1;
    l16   = 16'hA5F0;
    r16   = 16'h0F0F;
    l24   = 24'h800001;
    r24   = 24'h123456;
    repeat (3) tick();
    check("rst sdata16", bus16.sdata, 1'b0);
    check("rst sreq16", bus16.sample_req, 1'b0);
    check("rst ferr16", bus16.frame_err, 1'b0);
    check("rst sdata24", bus24.sdata, 1'b0);

    // Start-up with lrclk high: rising transition, right slot sends zeros.
    reset = 1'b0;
    run_half(32, 1'b1, -1, 16'h0, -1);
    check("start R16", b16, 32'h0);
    check("start R24", b24, 32'h0);
    check("start sreq", sq, 32'h0);
    check("start ferr", fe0, 1'b0);

    frame_chk("nom1", 32'hA5F0_0000, 32'h0F0F_0000, 32'h8000_0100, 32'h1234_5600, 1'b0);
    frame_chk("nom2", 32'hA5F0_0000, 32'h0F0F_0000, 32'h8000_0100, 32'h1234_5600, 1'b0);

    // Coherency: right changes mid left slot; old value still goes out.
    r16 = 16'h1234;
    run_half(32, 1'b0, 10, 16'h7FFF, -1);
    check("coh L16", b16, 32'hA5F0_0000);
    run_half(32, 1'b1, -1, 16'h0, -1);
    check("coh R16", b16, 32'h1234_0000);
    frame_chk("coh2", 32'hA5F0_0000, 32'h7FFF_0000, 32'h8000_0100, 32'h1234_5600, 1'b0);

    // Short left half of 30 bclk.
    run_half(30, 1'b0, -1, 16'h0, -1);
    check("short L16", b16, 32'hA5F0_0000);
    check("short L24", b24, 32'h8000_0100);
    check("short ferr before", bus16.frame_err, 1'b0);
    run_half(32, 1'b1, -1, 16'h0, -1);
    check("short ferr rise", fe0, 1'b1);
    check("short R16", b16, 32'h7FFF_0000);
    frame_chk("sticky", 32'hA5F0_0000, 32'h7FFF_0000, 32'h8000_0100, 32'h1234_5600, 1'b1);

    // Reset at bit 5 of the left slot.
    run_half(32, 1'b0, -1, 16'h0, 5);
    check("midrst L16", b16, 32'hA000_0000);
    check("midrst L24", b24, 32'h8000_0000);
    check("midrst sreq", sq, 32'h8000_0000);
    check("midrst ferr", bus16.frame_err, 1'b0);
    run_half(32, 1'b1, -1, 16'h0, -1);
    check("midrst R16", b16, 32'h0);
    check("midrst R24", b24, 32'h0);
    check("midrst ferr2", fe0, 1'b0);
    frame_chk("post_rst", 32'hA5F0_0000, 32'h7FFF_0000, 32'h8000_0100, 32'h1234_5600, 1'b0);

    // Reset on the falling transition edge: no capture, no pulse.
    run_half(32, 1'b0, -1, 16'h0, 0);
    check("trst L16", b16, 32'h0);
    check("trst sreq", sq, 32'h0);
    run_half(32, 1'b1, -1, 16'h0, -1);
    check("trst R16", b16, 32'h0);
    check("trst ferr", bus16.frame_err, 1'b0);

    // Negative full-scale sample after the reset.
    l16 = 16'h8000;
    frame_chk("post_trst", 32'h8000_0000, 32'h7FFF_0000, 32'h8000_0100, 32'h1234_5600, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
